rr_button_arbiter: RTL
======================

// Module: rr_button_arbiter
// PURPOSE
//  Round-robin arbiter sharing one downstream resource (display/action path) among
//  N pushbutton requesters; replaces fixed priority encoding so no requester starves.
//  Sits between the pb[] inputs and the consumer; grants one requester at a time,
//  holds the grant until release or timeout, then rotates priority past the winner.
// PARAMETERS
//  N         16   number of requesters
//  IDXW      4    width of encoded grant index, = clog2(N)
//  MAX_HOLD  100  max grant length in cycles (100 = 1 s at hz100); 0 = unlimited
//  GAP       1    idle cycles forced between grants (>=1)
// PORTS
//  hz100    in   1     clock, rising edge
//  reset    in   1     asynchronous, active-low reset
//  req      in   N     request vector, level-sensitive, bit i = requester i
//  grant    out  N     one-hot grant, registered; all-zero when no grant
//  gidx     out  IDXW  index of granted requester; valid only when gvalid=1
//  gvalid   out  1     a grant is active (equals |grant)
//  expired  out  1     one-cycle pulse: current grant ended by MAX_HOLD timeout
//  gcount   out  8     number of grants issued, wraps 255->0
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, grant=0, gidx=0, gvalid=0, expired=0,
//    gcount=0, ptr=0, hold_cnt=0, gap_cnt=0. Takes effect without a clock edge.
//  - All outputs registered. State machine IDLE -> GRANT -> GAPW -> IDLE.
//  - IDLE: if |req, winner = first i with req[i]=1 searching ptr, ptr+1, ..., N-1,
//    0, ..., ptr-1 (wrap). Next edge: grant[winner]=1, gidx=winner, gvalid=1,
//    gcount+=1, hold_cnt=0, state=GRANT. Latency req->grant: 1 edge. req=0: stay.
//  - GRANT: hold_cnt += 1 per cycle (saturating). Release on the edge where either
//    (a) req[gidx]=0 sampled, or (b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (grant
//    has been high exactly MAX_HOLD cycles). (a) takes precedence if both.
//    On release: grant=0, gvalid=0, ptr=(gidx+1) mod N, gap_cnt=0, state=GAPW;
//    expired=1 for that one cycle only if release was by (b).
//  - No preemption: other req bits changing during GRANT have no effect.
//  - GAPW: grant stays 0 for GAP cycles, then IDLE; new requests arriving in
//    GAPW are arbitrated in IDLE (earliest new grant = GAP+1 edges after release).
//  - Timed-out requester keeps no special status; if still requesting and alone,
//    it is re-granted after the gap; otherwise others come first via ptr.
//  - gidx holds last value when gvalid=0 (not cleared) except on reset.
//  - expired is 0 in all cycles other than the release cycle of a timeout.
//  - Illegal/unreachable state encodings return to IDLE with outputs cleared.
// TESTING
//  1. reset=0, req=0 -> all outputs 0; reset=1, req=16'h0001 -> 1 edge later
//     grant=16'h0001, gidx=0, gvalid=1, gcount=1.
//  2. MAX_HOLD=4, GAP=1, req=16'h0011 held -> grant bit0 4 cycles, expired pulse,
//     1 idle cycle, grant bit4 4 cycles, expired pulse, idle, grant bit0 again.
//  3. Wrap: grant req 14 then release (ptr=15); req=16'h4001 -> grant bit0, gidx=0.
//  4. Early release: grant bit3, drop req[3] after 2 cycles -> grant=0 next edge,
//     expired=0, ptr=4, gcount incremented once only.
//  5. Non-preemption: grant bit5, raise req[2] -> grant stays 16'h0020 until req[5]
//     drops; after gap, grant=16'h0004 only if req[2] still high.
//  6. Assert reset mid-grant between clock edges -> grant=0, gvalid=0, gidx=0,
//     gcount=0 immediately; after release with req=16'h0100, first grant is bit8.

Source files
------------

// File: rtl/rr_button_arbiter_if.sv
// Bundle between the pushbutton requesters/consumer and the round-robin arbiter.
// The arbiter connects through the slave modport; the requester/consumer side uses master.
interface rr_button_arbiter_if #(
    parameter int N    = 16,
    parameter int IDXW = 4
);
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] gidx;
    logic            gvalid;
    logic            expired;
    logic [7:0]      gcount;

    modport master (
        output req,
        input  grant,
        input  gidx,
        input  gvalid,
        input  expired,
        input  gcount
    );

    modport slave (
        input  req,
        output grant,
        output gidx,
        output gvalid,
        output expired,
        output gcount
    );
endinterface

// File: rtl/rr_button_arbiter.sv
// Round-robin arbiter granting one pushbutton requester at a time, holding the grant
// until release or MAX_HOLD timeout, then rotating priority past the winner.
module rr_button_arbiter #(
    parameter int N        = 16,
    parameter int IDXW     = 4,
    parameter int MAX_HOLD = 100,
    parameter int GAP      = 1
) (
    input  logic                hz100,
    input  logic                reset,
    rr_button_arbiter_if.slave  bus,
    output logic [1:0]          o_dbg_state
);
    // Handshake: req is level-sensitive (no ready); a grant is held while req[gidx]
    // stays high and drops on the first edge that samples it low or on timeout.

    localparam int HW = $clog2(MAX_HOLD + 2);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAPW  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_grant, w_grant_nxt;
    logic [IDXW-1:0] r_gidx, w_gidx_nxt;
    logic            r_gvalid, w_gvalid_nxt;
    logic            r_expired, w_expired_nxt;
    logic [7:0]      r_gcount, w_gcount_nxt;
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;
    logic [HW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic [GW-1:0]   r_gap_cnt, w_gap_cnt_nxt;

    logic            w_found;
    logic [IDXW-1:0] w_winner;
    logic [IDXW:0]   w_sum;
    logic            w_req_held;
    logic            w_timeout;
    logic [IDXW-1:0] w_ptr_after;

    // Rotating search starting at r_ptr; first hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IDXW + 1)'(k);
            if (w_sum >= (IDXW + 1)'(N)) begin
                w_sum = w_sum - (IDXW + 1)'(N);
            end
            if (!w_found && bus.req[w_sum[IDXW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDXW-1:0];
            end
        end
    end

    assign w_req_held  = bus.req[r_gidx];
    assign w_timeout   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_ptr_after = (r_gidx == IDXW'(N - 1)) ? '0 : r_gidx + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_gidx_nxt     = r_gidx;
        w_gvalid_nxt   = r_gvalid;
        w_expired_nxt  = 1'b0;
        w_gcount_nxt   = r_gcount;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt           = S_GRANT;
                    w_grant_nxt           = '0;
                    w_grant_nxt[w_winner] = 1'b1;
                    w_gidx_nxt            = w_winner;
                    w_gvalid_nxt          = 1'b1;
                    w_gcount_nxt          = r_gcount + 8'd1;
                    w_hold_cnt_nxt        = '0;
                end
            end

            S_GRANT: begin
                // A dropped request wins over a simultaneous timeout: no expired pulse.
                if (!w_req_held || w_timeout) begin
                    w_state_nxt   = S_GAPW;
                    w_grant_nxt   = '0;
                    w_gvalid_nxt  = 1'b0;
                    w_ptr_nxt     = w_ptr_after;
                    w_gap_cnt_nxt = '0;
                    w_expired_nxt = w_req_held;
                end else if (r_hold_cnt != '1) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end

            S_GAPW: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_grant_nxt  = '0;
                w_gidx_nxt   = '0;
                w_gvalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_gvalid   <= 1'b0;
            r_expired  <= 1'b0;
            r_gcount   <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gidx     <= w_gidx_nxt;
            r_gvalid   <= w_gvalid_nxt;
            r_expired  <= w_expired_nxt;
            r_gcount   <= w_gcount_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    assign bus.grant   = r_grant;
    assign bus.gidx    = r_gidx;
    assign bus.gvalid  = r_gvalid;
    assign bus.expired = r_expired;
    assign bus.gcount  = r_gcount;
    assign o_dbg_state = r_state;

endmodule
